decoder_2_4_pulse_seq: RTL and testbench



---
 rtl/decoder_2_4_pulse_seq.sv | 128 ++++++++++++
 tb/tb_decoder_2_4_pulse_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_2_4_pulse_seq.sv
// Sequenced 2-to-4 decoder: each accepted encoded index becomes a one-hot strobe held HOLD_CYCLES cycles.
// Optional feature macro: DECODER_ERRCNT_EN adds the err_cnt port and a saturating invalid-input counter.

module decoder_2_4_pulse_seq_param_chk #(
  parameter int HOLD_CYCLES = 4
) ();
  generate
    if ((HOLD_CYCLES < 1) || (HOLD_CYCLES > 255)) begin : g_bad_hold
      $error("decoder_2_4_pulse_seq: HOLD_CYCLES must be in 1..255");
    end
  endgenerate
endmodule

module decoder_2_4_pulse_seq #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] d_in,
  input  logic       invalid_input,
  output logic [3:0] d_out,
  output logic       busy
`ifdef DECODER_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  decoder_2_4_pulse_seq_param_chk #(.HOLD_CYCLES(HOLD_CYCLES)) u_param_chk ();

  state_e     state_q, state_d;
  logic [3:0] d_out_q, d_out_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       accept_s;

  // in_ready comes from the state register alone, so there is no path from in_valid back to in_ready.
  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q == ST_HOLD);
  assign d_out    = d_out_q;
  assign accept_s = in_valid & in_ready;

  // Next-state, strobe and hold-counter logic.
  always_comb begin
    state_d    = state_q;
    d_out_d    = d_out_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && !invalid_input) begin
          d_out_d    = 4'b0001 << d_in;
          hold_cnt_d = HOLD_LOAD;
          state_d    = ST_HOLD;
        end else begin
          d_out_d = 4'b0000;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q != 8'd0) begin
          hold_cnt_d = hold_cnt_q - 8'd1;
        end else begin
          d_out_d = 4'b0000;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        d_out_d    = 4'b0000;
        hold_cnt_d = 8'd0;
      end
    endcase
  end

  // State, strobe and hold-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      d_out_q    <= 4'b0000;
      hold_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      d_out_q    <= d_out_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

`ifdef DECODER_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    if (val == 8'hFF) begin
      return val;
    end else begin
      return val + 8'd1;
    end
  endfunction

  // Count accepted invalid inputs, sticking at 8'hFF.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept_s && invalid_input) begin
      err_cnt_d = sat_inc8(err_cnt_q);
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Error counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_decoder_2_4_pulse_seq.sv
// Directed self-checking bench for decoder_2_4_pulse_seq (default HOLD_CYCLES = 4).
// err_cnt checks are active when DECODER_ERRCNT_EN is defined.

module tb_decoder_2_4_pulse_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] d_in;
  logic       invalid_input;
  logic [3:0] d_out;
  logic       busy;
`ifdef DECODER_ERRCNT_EN
  logic [7:0] err_cnt;
  int         err_exp;
`endif

  int n_checks;
  int n_fail;

  decoder_2_4_pulse_seq #(.HOLD_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .d_in         (d_in),
    .invalid_input(invalid_input),
    .d_out        (d_out),
    .busy         (busy)
`ifdef DECODER_ERRCNT_EN
    ,
    .err_cnt      (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    d_in = 2'd2;
    invalid_input = 1'b0;
    step();
    step();
    n_checks++;
    if (d_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_d_out: got %b expected 0000", d_out);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
`ifdef DECODER_ERRCNT_EN
    err_exp = 0;
    n_checks++;
    if (err_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt);
    end
`endif
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    in_valid = 1'b1;
    d_in = 2'd2;
    invalid_input = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (d_out !== 4'b0100) begin
        n_fail++;
        $display("FAIL single_d_out[%0d]: got %b expected 0100", i, d_out);
      end
      n_checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL single_hold[%0d]: got in_ready=%b busy=%b expected 0/1", i, in_ready, busy);
      end
      d_in = 2'd1;
      invalid_input = 1'b1;
      step();
    end
    n_checks++;
    if (d_out !== 4'b0000 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_end: got d_out=%b in_ready=%b busy=%b expected 0000/1/0", d_out, in_ready, busy);
    end
    invalid_input = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_out [10];
    logic       exp_rdy [10];
    exp_out = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000,
                4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
    exp_rdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    in_valid = 1'b1;
    d_in = 2'd3;
    invalid_input = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (d_out !== exp_out[i]) begin
        n_fail++;
        $display("FAIL b2b_d_out[%0d]: got %b expected %b", i, d_out, exp_out[i]);
      end
      n_checks++;
      if (in_ready !== exp_rdy[i]) begin
        n_fail++;
        $display("FAIL b2b_in_ready[%0d]: got %b expected %b", i, in_ready, exp_rdy[i]);
      end
      if (i < 4) d_in = 2'd1;
      else if (i == 4) d_in = 2'd0;
      else d_in = 2'd2;
      if (i == 9) in_valid = 1'b0;
      step();
    end
  endtask

  task automatic test_invalid();
    in_valid = 1'b1;
    invalid_input = 1'b1;
    d_in = 2'd3;
    for (int i = 0; i < 3; i++) begin
      step();
`ifdef DECODER_ERRCNT_EN
      err_exp++;
      n_checks++;
      if (err_cnt !== 8'(err_exp)) begin
        n_fail++;
        $display("FAIL invalid_err_cnt[%0d]: got %0d expected %0d", i, err_cnt, err_exp);
      end
`endif
      n_checks++;
      if (d_out !== 4'b0000 || in_ready !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL invalid_idle[%0d]: got d_out=%b in_ready=%b busy=%b expected 0000/1/0", i, d_out, in_ready, busy);
      end
    end
    in_valid = 1'b0;
    invalid_input = 1'b0;
    step();
`ifdef DECODER_ERRCNT_EN
    n_checks++;
    if (err_cnt !== 8'(err_exp)) begin
      n_fail++;
      $display("FAIL invalid_err_hold: got %0d expected %0d", err_cnt, err_exp);
    end
`endif
  endtask

  task automatic test_reset_mid_hold();
    in_valid = 1'b1;
    d_in = 2'd1;
    invalid_input = 1'b0;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (d_out !== 4'b0010) begin
      n_fail++;
      $display("FAIL midrst_strobe: got %b expected 0010", d_out);
    end
    step();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (d_out !== 4'b0000 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_async: got d_out=%b busy=%b in_ready=%b expected 0000/0/1", d_out, busy, in_ready);
    end
`ifdef DECODER_ERRCNT_EN
    err_exp = 0;
    n_checks++;
    if (err_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL midrst_err_cnt: got %0d expected 0", err_cnt);
    end
`endif
    step();
    rst_n = 1'b1;
    step();
    n_checks++;
    if (in_ready !== 1'b1 || d_out !== 4'b0000) begin
      n_fail++;
      $display("FAIL midrst_release: got in_ready=%b d_out=%b expected 1/0000", in_ready, d_out);
    end
    in_valid = 1'b1;
    d_in = 2'd0;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (d_out !== 4'b0001) begin
      n_fail++;
      $display("FAIL midrst_reaccept: got %b expected 0001", d_out);
    end
    repeat (5) step();
  endtask

  task automatic test_saturation();
    in_valid = 1'b1;
    invalid_input = 1'b1;
    d_in = 2'd2;
    for (int i = 0; i < 300; i++) begin
      step();
      n_checks++;
      if (d_out !== 4'b0000 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL sat_idle[%0d]: got d_out=%b in_ready=%b expected 0000/1", i, d_out, in_ready);
      end
`ifdef DECODER_ERRCNT_EN
      if (err_exp < 255) err_exp++;
      n_checks++;
      if (err_cnt !== 8'(err_exp)) begin
        n_fail++;
        $display("FAIL sat_err_cnt[%0d]: got %0d expected %0d", i, err_cnt, err_exp);
      end
`endif
    end
    in_valid = 1'b0;
    invalid_input = 1'b0;
    step();
`ifdef DECODER_ERRCNT_EN
    n_checks++;
    if (err_cnt !== 8'hFF) begin
      n_fail++;
      $display("FAIL sat_final: got %0d expected 255", err_cnt);
    end
`endif
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_invalid();
    test_reset_mid_hold();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
